pipe_skid_register: RTL and testbench
=====================================

PIPE_SKID_REGISTER -- requirements
Module: pipe_skid_register

Interface
REQ-001 Parameter DW, default 64: data payload width in bits (ALU result plus memory output in the MEM/WB usage).
REQ-002 Parameter CW, default 7: control payload width in bits (5-bit destination register plus wreg and m2reg).
REQ-003 Parameter CMASK, default 7'b0000011: per-bit mask of control bits forced to 0 whenever out_valid is 0.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 clrn  input  1  reset, asynchronous, active-low.
REQ-006 flush  input  1  synchronous squash of all held entries.
REQ-007 in_valid  input  1  upstream presents a valid entry.
REQ-008 in_ready  output  1  stage can accept an entry this cycle; registered.
REQ-009 in_data  input  DW  upstream data payload.
REQ-010 in_ctrl  input  CW  upstream control payload.
REQ-011 out_valid  output  1  stage presents a valid entry.
REQ-012 out_ready  input  1  downstream accepts an entry this cycle.
REQ-013 out_data  output  DW  head-entry data.
REQ-014 out_ctrl  output  CW  head-entry control, with CMASK bits gated by out_valid.
REQ-015 occupancy  output  2  number of held entries: 0, 1 or 2.

Function
REQ-016 The stage shall hold up to two entries: a main register driving the outputs and a skid register; the state is EMPTY, ONE or FULL.
REQ-017 An input transfer shall occur when in_valid and in_ready are both 1; an output transfer shall occur when out_valid and out_ready are both 1.
REQ-018 EMPTY transitions: input transfer -> ONE; otherwise stay EMPTY.
REQ-019 ONE transitions: input without output -> FULL (new entry to skid); output without input -> EMPTY; both -> ONE, with the main register loaded with the new entry.
REQ-020 FULL transitions: output -> ONE, with skid moved to main; otherwise stay FULL. No input transfer is possible in FULL.
REQ-021 in_ready shall be 1 in EMPTY and ONE and 0 in FULL, and shall be driven only from registered state, with no combinational path from out_ready.
REQ-022 Latency: an entry accepted at edge t shall appear with out_valid=1 after edge t when the stage was EMPTY.
REQ-023 Entries shall leave in acceptance order; none shall be duplicated or dropped except by flush.
REQ-024 out_data and out_ctrl shall hold their previous value while the head is stalled (out_valid=1, out_ready=0).
REQ-025 When out_valid is 0, out_ctrl bits selected by CMASK shall read 0; other bits and out_data are don't-care but shall be deterministic.
REQ-026 flush shall empty the stage at the next edge (state EMPTY, occupancy 0) and shall take priority over a simultaneous input transfer, whose entry is discarded.
REQ-027 A simultaneous output transfer on a flush cycle shall still count as delivered downstream.
REQ-028 occupancy shall equal 0, 1 or 2 for EMPTY, ONE or FULL respectively.

Reset
REQ-029 On clrn=0, the stage shall immediately enter EMPTY, with out_valid=0, occupancy=0, out_data=0, out_ctrl=0, skid contents=0 and in_ready=1.
REQ-030 Reset asserted mid-operation shall discard all entries; the first accepted entry after release shall behave per REQ-022.

Structure
REQ-031 The shared package cpu_pipe_pkg shall hold the state encoding (EMPTY=2'd0, ONE=2'd1, FULL=2'd2) and the default MEM/WB widths (DATA_W=64, CTRL_W=7, WB_CMASK).
REQ-032 The block shall be a single module with no sub-modules; the MEM/WB instance shall concatenate {alu, mo} onto data and {rn, wreg, m2reg} onto ctrl.

Verification
REQ-033 Reset, then in_valid=1 with data 0x0000_0005_0000_0007 and out_ready=1 -> the next cycle shows out_valid=1 with that data, and occupancy stays at most 1 under continuous streaming.
REQ-034 Stream 3 entries A, B, C with out_ready=0 -> A and B are accepted, in_ready=0 with occupancy=2, C is held upstream; releasing out_ready delivers A, B, C in order.
REQ-035 In FULL, assert flush together with out_ready=1 -> A is delivered that cycle, then occupancy=0, out_valid=0, out_ctrl[1:0]=0 and in_ready=1.
REQ-036 In ONE, assert flush with in_valid=1 -> the new entry is discarded and occupancy=0.
REQ-037 Drop clrn asynchronously mid-stream at occupancy=2 -> out_valid=0 and out_ctrl=0 immediately, without waiting for a clock edge.
REQ-038 Random valid/ready with no flush for 10k cycles -> a scoreboard shows no loss, duplication or reordering, and in_ready never depends combinationally on out_ready.

Source files
------------

// File: rtl/cpu_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pipe_pkg
//  Description : Shared pipeline definitions. Holds the skid-stage state
//                encoding and the default MEM/WB payload widths and the
//                control-gating mask.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pipe_pkg;

  // Occupancy of a two-entry skid stage. The encoding doubles as the
  // occupancy count, so it must stay 0/1/2.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  // MEM/WB payload: data = {alu, mo}, ctrl = {rn[4:0], wreg, m2reg}
  localparam int          DATA_W   = 64;
  localparam int          CTRL_W   = 7;
  // wreg and m2reg must never be seen asserted on a bubble
  localparam logic [6:0]  WB_CMASK = 7'b0000011;

endpackage
`default_nettype wire

// File: rtl/pipe_skid_register.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_skid_register
//  Description : Two-entry valid/ready pipeline register with a skid slot.
//                in_ready is decoded from registered state only, so the
//                downstream ready never reaches upstream combinationally.
//                Entries leave in acceptance order; flush empties the stage.
//  Ports       : clk        - clock, rising edge
//                clrn       - asynchronous active-low reset
//                flush      - synchronous squash of held entries
//                in_valid   - upstream entry valid
//                in_ready   - stage can accept (registered-state decode)
//                in_data    - upstream data payload  [DW]
//                in_ctrl    - upstream control payload [CW]
//                out_valid  - head entry valid
//                out_ready  - downstream accepts head
//                out_data   - head data [DW]
//                out_ctrl   - head control [CW], CMASK bits gated by out_valid
//                occupancy  - held entries 0..2
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_register
  import cpu_pipe_pkg::*;
#(
  parameter int            DW    = DATA_W,
  parameter int            CW    = CTRL_W,
  parameter logic [CW-1:0] CMASK = WB_CMASK
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic [CW-1:0] in_ctrl,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [CW-1:0] out_ctrl,
  output logic [1:0]    occupancy
);

  skid_state_e   r_state;
  skid_state_e   w_state_nxt;

  logic [DW-1:0] r_main_data;
  logic [CW-1:0] r_main_ctrl;
  logic [DW-1:0] r_skid_data;
  logic [CW-1:0] r_skid_ctrl;

  logic          w_in_ready;
  logic          w_out_valid;
  logic          w_in_xfer;
  logic          w_out_xfer;
  logic          w_load_main_in;    // main <- upstream entry
  logic          w_load_main_skid;  // main <- skid entry
  logic          w_load_skid;       // skid <- upstream entry

  // Both handshake qualifiers come from the state register alone.
  assign w_in_ready  = (r_state != FULL);
  assign w_out_valid = (r_state != EMPTY);
  assign w_in_xfer   = in_valid & w_in_ready;
  assign w_out_xfer  = w_out_valid & out_ready;

  // --------------------------------------------------------------------------
  // Next-state and register load decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;

    if (flush) begin
      // Any accepted input this cycle is discarded; a head handed over on
      // the same cycle has already been taken downstream.
      w_state_nxt = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_xfer) begin
            w_state_nxt    = ONE;
            w_load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (w_in_xfer && !w_out_xfer) begin
            w_state_nxt = FULL;
            w_load_skid = 1'b1;
          end else if (!w_in_xfer && w_out_xfer) begin
            w_state_nxt = EMPTY;
          end else if (w_in_xfer && w_out_xfer) begin
            w_load_main_in = 1'b1;
          end
        end
        FULL: begin
          if (w_out_xfer) begin
            w_state_nxt      = ONE;
            w_load_main_skid = 1'b1;
          end
        end
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Payload registers: only written on a load, so a stalled head holds.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_main_data <= '0;
      r_main_ctrl <= '0;
    end else if (w_load_main_in) begin
      r_main_data <= in_data;
      r_main_ctrl <= in_ctrl;
    end else if (w_load_main_skid) begin
      r_main_data <= r_skid_data;
      r_main_ctrl <= r_skid_ctrl;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_skid_data <= '0;
      r_skid_ctrl <= '0;
    end else if (w_load_skid) begin
      r_skid_data <= in_data;
      r_skid_ctrl <= in_ctrl;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = r_main_data;
  // Masked control bits read 0 on a bubble; the rest keep the stale value.
  assign out_ctrl  = w_out_valid ? r_main_ctrl : (r_main_ctrl & ~CMASK);
  assign occupancy = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_register.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_skid_register
//  Description : Self-checking bench for pipe_skid_register: directed
//                reset / streaming / backpressure / flush / async-reset
//                steps followed by a random valid/ready phase against a
//                queue reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_skid_register;

  localparam int DW = 64;
  localparam int CW = 7;

  logic          clk;
  logic          clrn;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [1:0]    occupancy;

  int n_cmp = 0;
  int n_err = 0;

  pipe_skid_register #(
    .DW   (DW),
    .CW   (CW),
    .CMASK(7'b0000011)
  ) dut (
    .clk      (clk),
    .clrn     (clrn),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_ctrl  (in_ctrl),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ctrl (out_ctrl),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance one edge and sample 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [63:0] D0 = 64'h0000_0005_0000_0007;
  localparam logic [63:0] D1 = 64'h0000_0005_0000_0009;
  localparam logic [63:0] DA = 64'hAAAA_0000_1111_0001;
  localparam logic [63:0] DB = 64'hBBBB_0000_2222_0002;
  localparam logic [63:0] DC = 64'hCCCC_0000_3333_0003;
  localparam logic [63:0] DX = 64'hDEAD_BEEF_DEAD_BEEF;

  logic [DW+CW-1:0] q[$];
  logic [DW+CW-1:0] head;
  logic             rdy_before;
  logic             do_push, do_pop;
  int               guard;

  initial begin
    clrn      = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_ctrl   = '0;
    out_ready = 1'b0;

    // ---------------- reset state, before any clock edge ----------------
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_occ",       64'(occupancy), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_data",  out_data,       64'd0);
    chk("rst_out_ctrl",  64'(out_ctrl),  64'd0);
    step();
    step();
    clrn = 1'b1;

    // ---------------- single entry latency and streaming ----------------
    in_valid = 1'b1; in_data = D0; in_ctrl = 7'h5B; out_ready = 1'b1;
    step();
    chk("lat_out_valid", 64'(out_valid), 64'd1);
    chk("lat_out_data",  out_data,       D0);
    chk("lat_out_ctrl",  64'(out_ctrl),  64'h5B);
    chk("lat_occ",       64'(occupancy), 64'd1);
    in_data = D1; in_ctrl = 7'h22;
    step();
    chk("stream_out_data", out_data,       D1);
    chk("stream_occ",      64'(occupancy), 64'd1);
    in_valid = 1'b0;
    step();
    chk("drain_out_valid", 64'(out_valid),          64'd0);
    chk("drain_occ",       64'(occupancy),          64'd0);
    chk("drain_ctrl_mask", 64'(out_ctrl & 7'h03),   64'd0);

    // ---------------- backpressure: A, B accepted, C held ---------------
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = DA; in_ctrl = 7'h0A;
    step();
    chk("bp1_occ",      64'(occupancy), 64'd1);
    chk("bp1_in_ready", 64'(in_ready),  64'd1);
    chk("bp1_out_data", out_data,       DA);
    in_data = DB; in_ctrl = 7'h0B;
    step();
    chk("bp2_occ",      64'(occupancy), 64'd2);
    chk("bp2_in_ready", 64'(in_ready),  64'd0);
    chk("bp2_out_data", out_data,       DA);
    in_data = DC; in_ctrl = 7'h0C;
    step();
    chk("bp3_occ",      64'(occupancy), 64'd2);
    chk("bp3_hold_data", out_data,      DA);
    chk("bp3_hold_ctrl", 64'(out_ctrl), 64'h0A);
    out_ready = 1'b1;
    step();
    chk("rel1_out_data", out_data,       DB);
    chk("rel1_out_ctrl", 64'(out_ctrl),  64'h0B);
    chk("rel1_occ",      64'(occupancy), 64'd1);
    step();
    in_valid = 1'b0;
    chk("rel2_out_data", out_data,       DC);
    chk("rel2_out_ctrl", 64'(out_ctrl),  64'h0C);
    chk("rel2_occ",      64'(occupancy), 64'd1);
    step();
    chk("rel3_out_valid", 64'(out_valid), 64'd0);

    // ---------------- flush in FULL with simultaneous delivery ----------
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = DA; in_ctrl = 7'h0F;
    step();
    in_data = DB; in_ctrl = 7'h0B;
    step();
    in_valid = 1'b0; flush = 1'b1; out_ready = 1'b1;
    #1;
    chk("fl_full_occ",     64'(occupancy), 64'd2);
    chk("fl_deliver_valid", 64'(out_valid), 64'd1);
    chk("fl_deliver_data", out_data,       DA);
    step();
    flush = 1'b0;
    chk("fl_occ",       64'(occupancy),        64'd0);
    chk("fl_out_valid", 64'(out_valid),        64'd0);
    chk("fl_ctrl_mask", 64'(out_ctrl & 7'h03), 64'd0);
    chk("fl_in_ready",  64'(in_ready),         64'd1);

    // ---------------- flush in ONE discards a simultaneous input --------
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = DC; in_ctrl = 7'h03;
    step();
    chk("fl1_pre_occ", 64'(occupancy), 64'd1);
    in_data = DX; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl1_occ", 64'(occupancy), 64'd0);
    step();
    chk("fl1_discard_occ",   64'(occupancy), 64'd0);
    chk("fl1_discard_valid", 64'(out_valid), 64'd0);

    // ---------------- asynchronous reset at occupancy 2 -----------------
    in_valid = 1'b1; in_data = DA; in_ctrl = 7'h7F;
    step();
    in_data = DB;
    step();
    in_valid = 1'b0;
    chk("ar_pre_occ", 64'(occupancy), 64'd2);
    #2 clrn = 1'b0;
    #1;
    chk("ar_out_valid", 64'(out_valid), 64'd0);
    chk("ar_out_ctrl",  64'(out_ctrl),  64'd0);
    chk("ar_out_data",  out_data,       64'd0);
    chk("ar_occ",       64'(occupancy), 64'd0);
    chk("ar_in_ready",  64'(in_ready),  64'd1);
    step();
    clrn = 1'b1;
    in_valid = 1'b1; in_data = DC; in_ctrl = 7'h11; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("ar_post_valid", 64'(out_valid), 64'd1);
    chk("ar_post_data",  out_data,       DC);
    step();

    // ---------------- random valid/ready against a queue model ----------
    q.delete();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = {$urandom, $urandom};
      in_ctrl   = 7'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      chk("rnd_occ",      64'(occupancy), 64'(q.size()));
      chk("rnd_in_ready", 64'(in_ready),  64'(q.size() < 2));
      // in_ready must not move when only out_ready changes
      rdy_before = in_ready;
      out_ready  = ~out_ready;
      #1;
      chk("rnd_ready_path", 64'(in_ready), 64'(rdy_before));
      out_ready  = ~out_ready;
      #1;
      do_push = in_valid && in_ready;
      do_pop  = out_valid && out_ready;
      if (do_pop) begin
        if (q.size() == 0) begin
          chk("rnd_spurious_out", 64'(out_valid), 64'd0);
        end else begin
          head = q.pop_front();
          chk("rnd_out_data", out_data,      head[DW+CW-1:CW]);
          chk("rnd_out_ctrl", 64'(out_ctrl), 64'(head[CW-1:0]));
        end
      end
      if (do_push) q.push_back({in_data, in_ctrl});
      step();
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    guard     = 0;
    while (occupancy != 2'd0 && guard < 8) begin
      #1;
      if (out_valid && q.size() != 0) begin
        head = q.pop_front();
        chk("end_out_data", out_data, head[DW+CW-1:CW]);
      end
      step();
      guard++;
    end
    chk("end_occ",   64'(occupancy), 64'd0);
    chk("end_queue", 64'(q.size()),  64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
